// File: rtl/miner_nonce_arbiter.sv
// miner_nonce_arbiter: hands interleaved nonces to CORES hash cores and realigns
// their results across PIPE_LAT cycles. Hashes whose top bits meet the difficulty
// are queued in a small first-word-fallthrough FIFO that is drained with valid/ready.
// Optional build macro MINER_DIFF_RUNTIME_EN: adds i_difficulty [5:0], sampled on start.

// Per-core lane: issued nonce, realigned nonce and difficulty hit flag
module miner_nonce_lane #(
    parameter int HASH_W = 32,
    parameter int LANE   = 0
) (
    input  logic [31:0]       i_run_cnt,
    input  logic [31:0]       i_dly_cnt,
    input  logic              i_dly_vld,
    input  logic              i_hash_valid,
    input  logic [HASH_W-1:0] i_hash,
    input  logic [HASH_W-1:0] i_mask,
    output logic [31:0]       o_nonce,
    output logic [31:0]       o_hit_nonce,
    output logic              o_hit
);
    assign o_nonce     = i_run_cnt + 32'(LANE);
    assign o_hit_nonce = i_dly_cnt + 32'(LANE);
    assign o_hit       = i_dly_vld & i_hash_valid & ~|(i_hash & i_mask);
endmodule

module miner_nonce_arbiter #(
    parameter int CORES      = 4,
    parameter int HASH_W     = 32,
    parameter int DIFFICULTY = 12,
    parameter int PIPE_LAT   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         i_hash_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic [31:0]                  i_nonce_base,
`ifdef MINER_DIFF_RUNTIME_EN
    input  logic [5:0]                   i_difficulty,
`endif
    output logic [CORES-1:0][31:0]       o_core_nonce,
    input  logic [CORES-1:0][HASH_W-1:0] i_core_hash,
    input  logic [CORES-1:0]             i_core_hash_valid,
    output logic                         o_busy,
    output logic                         o_exhausted,
    output logic                         o_golden_valid,
    input  logic                         i_golden_ready,
    output logic [31:0]                  o_golden_nonce,
    output logic [3:0]                   o_golden_core,
    output logic [7:0]                   o_drop_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = $clog2(PIPE_LAT + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                   r_state, w_next;
    logic [31:0]              r_counter;
    logic                     r_exhausted;
    logic [DCW-1:0]           r_drain_cnt;
    logic [7:0]               r_drop;
    logic                     w_busy, w_run, w_accept, w_carry, w_drain_done;
    logic [31:0]              w_dly_cnt;
    logic                     w_dly_vld;
    logic [HASH_W-1:0]        w_mask;
    logic [CORES-1:0][31:0]   w_lane_nonce, w_hit_nonce;
    logic [CORES-1:0]         w_hit;
    logic                     w_any_hit;
    logic [3:0]               w_win_idx;
    logic [31:0]              w_win_nonce;
    logic [4:0]               w_hit_cnt, w_drops;
    logic [8:0]               w_drop_sum;
    logic [7:0]               w_drop_next;

    logic [31:0]              r_mem_nonce [FIFO_DEPTH];
    logic [3:0]               r_mem_core  [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     w_full, w_push, w_pop;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_carry      = 1'(({1'b0, r_counter} + 33'(CORES)) >> 32);
    assign w_drain_done = (r_drain_cnt == DCW'(PIPE_LAT));

    // State register
    always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: last batch still goes out on the stop/wrap cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (i_stop || w_carry) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs; nonces read as zero while idle
    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_run  = (r_state == S_RUN);
        for (int i = 0; i < CORES; i++)
            o_core_nonce[i] = w_busy ? w_lane_nonce[i] : 32'd0;
    end

    // Nonce counter and sticky wrap flag; counter freezes on the final batch
    always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_counter   <= '0;
            r_exhausted <= 1'b0;
        end else if (w_accept) begin
            r_counter   <= i_nonce_base;
            r_exhausted <= 1'b0;
        end else if (w_run) begin
            if (w_carry) r_exhausted <= 1'b1;
            if (!(i_stop || w_carry)) r_counter <= r_counter + 32'(CORES);
        end
    end

    // Drain length covers the pipeline so the last batch is still evaluated
    always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_drain_cnt <= '0;
        else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
        else                         r_drain_cnt <= '0;
    end

`ifdef MINER_DIFF_RUNTIME_EN
    logic [7:0] r_diff, w_diff_clamp;

    // Clamp requested difficulty to 1..HASH_W
    always_comb begin
        w_diff_clamp = {2'b00, i_difficulty};
        if (w_diff_clamp == 8'd0)            w_diff_clamp = 8'd1;
        else if (w_diff_clamp > 8'(HASH_W)) w_diff_clamp = 8'(HASH_W);
    end

    // Difficulty held for the whole run including drain
    always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_diff <= 8'(DIFFICULTY);
        else if (w_accept) r_diff <= w_diff_clamp;
    end

    assign w_mask = ~({HASH_W{1'b1}} >> r_diff);
`else
    assign w_mask = ~({HASH_W{1'b1}} >> DIFFICULTY);
`endif

    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign w_dly_cnt = r_counter;
            assign w_dly_vld = w_run;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0][31:0] r_cnt_pipe;
            logic [PIPE_LAT-1:0]       r_vld_pipe;

            // Delay batch base and run-valid to meet the core results
            always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt_pipe <= '0;
                    r_vld_pipe <= '0;
                end else begin
                    r_cnt_pipe[0] <= r_counter;
                    r_vld_pipe[0] <= w_run;
                    for (int k = 1; k < PIPE_LAT; k++) begin
                        r_cnt_pipe[k] <= r_cnt_pipe[k-1];
                        r_vld_pipe[k] <= r_vld_pipe[k-1];
                    end
                end
            end

            assign w_dly_cnt = r_cnt_pipe[PIPE_LAT-1];
            assign w_dly_vld = r_vld_pipe[PIPE_LAT-1];
        end

        for (genvar g = 0; g < CORES; g++) begin : g_lane
            miner_nonce_lane #(.HASH_W(HASH_W), .LANE(g)) u_lane (
                .i_run_cnt   (r_counter),
                .i_dly_cnt   (w_dly_cnt),
                .i_dly_vld   (w_dly_vld),
                .i_hash_valid(i_core_hash_valid[g]),
                .i_hash      (i_core_hash[g]),
                .i_mask      (w_mask),
                .o_nonce     (w_lane_nonce[g]),
                .o_hit_nonce (w_hit_nonce[g]),
                .o_hit       (w_hit[g])
            );
        end
    endgenerate

    // Lowest-index hit wins the single push slot; count all hits
    always_comb begin
        w_any_hit   = 1'b0;
        w_win_idx   = '0;
        w_win_nonce = '0;
        w_hit_cnt   = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit   = 1'b1;
                w_win_idx   = 4'(i);
                w_win_nonce = w_hit_nonce[i];
            end
        end
        for (int i = 0; i < CORES; i++)
            w_hit_cnt = w_hit_cnt + {4'd0, w_hit[i]};
    end

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = (r_count != '0) && i_golden_ready;
    assign w_push      = w_any_hit && (!w_full || w_pop);
    assign w_drops     = w_hit_cnt - {4'd0, w_push};
    assign w_drop_sum  = {1'b0, r_drop} + {4'd0, w_drops};
    assign w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    // Saturating drop counter, cleared when a new run is accepted
    always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_drop <= '0;
        else if (w_accept) r_drop <= '0;
        else               r_drop <= w_drop_next;
    end

    // Golden FIFO: storage, pointers and occupancy; survives across runs
    always_ff @(posedge i_hash_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem_nonce[k] <= '0;
                r_mem_core[k]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_nonce[r_wr_ptr] <= w_win_nonce;
                r_mem_core[r_wr_ptr]  <= w_win_idx;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy         = w_busy;
    assign o_exhausted    = r_exhausted;
    assign o_golden_valid = (r_count != '0);
    assign o_golden_nonce = r_mem_nonce[r_rd_ptr];
    assign o_golden_core  = r_mem_core[r_rd_ptr];
    assign o_drop_count   = r_drop;
endmodule
